// File: rtl/peribus_pkg.sv
// Shared register map, field positions and CTRL layout for the peripheral-bus timer.
package peribus_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PRE_W  = 8;
    localparam int unsigned OFS_W  = 2;

    localparam logic [OFS_W-1:0] CTRL_OFS    = 2'd0;
    localparam logic [OFS_W-1:0] COMPARE_OFS = 2'd1;
    localparam logic [OFS_W-1:0] COUNT_OFS   = 2'd2;
    localparam logic [OFS_W-1:0] STATUS_OFS  = 2'd3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_AR_BIT      = 1;
    localparam int unsigned CTRL_IE_BIT      = 2;
    localparam int unsigned CTRL_PS_LSB      = 8;
    localparam int unsigned CTRL_PS_MSB      = 15;
    localparam int unsigned STATUS_MATCH_BIT = 0;
    localparam int unsigned STATUS_RUN_BIT   = 1;

    typedef struct packed {
        logic [PRE_W-1:0] prescale;
        logic [4:0]       rsvd;
        logic             irq_en;
        logic             auto_reload;
        logic             enable;
    } ctrl_t;

    // Build a CTRL value from a bus word; reserved bits always read back as zero.
    function automatic ctrl_t ctrl_from_word(input logic [DATA_W-1:0] w);
        ctrl_t c;
        c             = '0;
        c.enable      = w[CTRL_EN_BIT];
        c.auto_reload = w[CTRL_AR_BIT];
        c.irq_en      = w[CTRL_IE_BIT];
        c.prescale    = w[CTRL_PS_MSB:CTRL_PS_LSB];
        return c;
    endfunction

endpackage

// File: rtl/peri_timer_if.sv
// Peripheral bus as seen by one slave: write strobe, read request, registered read data, irq.
interface peri_timer_if;
    import peribus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic              read_enable;
    logic [DATA_W-1:0] read_data;
    logic              irq;

    modport master (
        output addr, write_data, write_enable, read_enable,
        input  read_data, irq
    );

    modport slave (
        input  addr, write_data, write_enable, read_enable,
        output read_data, irq
    );

endinterface

// File: rtl/peri_prescaler.sv
// 8-bit prescaler: ticks when pre reaches the divisor, then restarts from zero.
module peri_prescaler
    import peribus_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [PRE_W-1:0] divisor,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = enable && (pre_q == divisor);

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (!enable || clear || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// 16-bit timer/compare peripheral: 4-register window, one-shot or auto-reload, level irq.
module peri_timer
    import peribus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 8'h10,
    parameter logic [DATA_W-1:0] RESET_COMPARE = 16'hFFFF
) (
    input logic         peribus_clock,
    input logic         reset,
    peri_timer_if.slave bus
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              match_q, match_d;

    logic              hit;
    logic              wr_hit;
    logic              rd_hit;
    logic [OFS_W-1:0]  ofs;
    logic              pre_clear;
    logic              tick;
    logic              match_evt;
    logic [DATA_W-1:0] status_word;

    // Address decode and prescaler clear requests (COUNT load, CTRL write disabling).
    always_comb begin
        hit       = bus.addr[ADDR_W-1:OFS_W] == BASE_ADDR[ADDR_W-1:OFS_W];
        ofs       = bus.addr[OFS_W-1:0];
        wr_hit    = bus.write_enable && hit;
        rd_hit    = bus.read_enable && hit;
        pre_clear = 1'b0;
        if (wr_hit) begin
            if (ofs == COUNT_OFS) begin
                pre_clear = 1'b1;
            end else if (ofs == CTRL_OFS && !bus.write_data[CTRL_EN_BIT]) begin
                pre_clear = 1'b1;
            end
        end
    end

    peri_prescaler u_prescaler (
        .clock   (peribus_clock),
        .reset   (reset),
        .enable  (ctrl_q.enable),
        .clear   (pre_clear),
        .divisor (ctrl_q.prescale),
        .tick    (tick)
    );

    assign match_evt = tick && (count_q == compare_q);

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_MATCH_BIT] = match_q;
        status_word[STATUS_RUN_BIT]   = ctrl_q.enable;
    end

    // Next state: W1C first, then tick effects, then register writes override the tick.
    always_comb begin
        ctrl_d      = ctrl_q;
        compare_d   = compare_q;
        count_d     = count_q;
        match_d     = match_q;
        read_data_d = '0;

        if (wr_hit && ofs == STATUS_OFS && bus.write_data[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end

        if (tick) begin
            if (match_evt) begin
                match_d = 1'b1;
                if (ctrl_q.auto_reload) begin
                    count_d = '0;
                end else begin
                    ctrl_d.enable = 1'b0;
                end
            end else begin
                count_d = count_q + DATA_W'(1);
            end
        end

        if (wr_hit) begin
            case (ofs)
                CTRL_OFS:    ctrl_d    = ctrl_from_word(bus.write_data);
                COMPARE_OFS: compare_d = bus.write_data;
                COUNT_OFS:   count_d   = bus.write_data;
                default:     ;
            endcase
        end

        if (rd_hit) begin
            case (ofs)
                CTRL_OFS:    read_data_d = DATA_W'(ctrl_q);
                COMPARE_OFS: read_data_d = compare_q;
                COUNT_OFS:   read_data_d = count_q;
                default:     read_data_d = status_word;
            endcase
        end
    end

    always_ff @(posedge peribus_clock) begin
        if (reset) begin
            ctrl_q      <= '0;
            compare_q   <= RESET_COMPARE;
            count_q     <= '0;
            match_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            compare_q   <= compare_d;
            count_q     <= count_d;
            match_q     <= match_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.irq       = match_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_peri_timer.sv
// Self-checking bench for peri_timer: vector table, directed corner sequences, random vs model.
module tb_peri_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    peri_timer_if bus_if ();

    peri_timer #(
        .BASE_ADDR     (BASE),
        .RESET_COMPARE (16'hFFFF)
    ) dut (
        .peribus_clock (clk),
        .reset         (rst),
        .bus           (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (spec-level view of the registers).
    logic        m_en, m_ar, m_ie, m_match;
    int          m_ps, m_pre;
    logic [15:0] m_cmp, m_cnt, m_rd;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vtab[14];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        logic        hit, tk, hit_cmp;
        int          ofs, nxt_pre;
        logic [15:0] w;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_pre = 0;
            m_cmp = 16'hFFFF; m_cnt = 0; m_match = 0; m_rd = 0;
            return;
        end
        hit = (int'(bus_if.addr) / 4) == (int'(BASE) / 4);
        ofs = int'(bus_if.addr) % 4;
        w   = bus_if.write_data;
        m_rd = 16'h0000;
        if (bus_if.read_enable && hit) begin
            case (ofs)
                0: m_rd = {8'(m_ps), 5'b0, m_ie, m_ar, m_en};
                1: m_rd = m_cmp;
                2: m_rd = m_cnt;
                default: m_rd = {14'b0, m_en, m_match};
            endcase
        end
        tk      = m_en && (m_pre == m_ps);
        hit_cmp = tk && (m_cnt == m_cmp);
        nxt_pre = (!m_en || tk) ? 0 : (m_pre + 1) % 256;
        if (bus_if.write_enable && hit && ofs == 3 && w[0] && !hit_cmp) m_match = 0;
        if (tk) begin
            if (hit_cmp) begin
                m_match = 1;
                if (m_ar) m_cnt = 16'h0000;
                else      m_en  = 0;
            end else begin
                m_cnt = 16'((int'(m_cnt) + 1) % 65536);
            end
        end
        if (bus_if.write_enable && hit) begin
            case (ofs)
                0: begin
                    m_en = w[0]; m_ar = w[1]; m_ie = w[2]; m_ps = int'(w[15:8]);
                    if (!w[0]) nxt_pre = 0;
                end
                1: m_cmp = w;
                2: begin m_cnt = w; nxt_pre = 0; end
                default: ;
            endcase
        end
        m_pre = nxt_pre;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.write_enable = 1'b0;
        bus_if.read_enable  = 1'b0;
        bus_if.addr         = 8'h00;
        bus_if.write_data   = 16'h0000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus_if.addr = a; bus_if.write_data = d;
        bus_if.write_enable = 1'b1; bus_if.read_enable = 1'b0;
        cyc();
        bus_if.write_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        bus_if.addr = a; bus_if.read_enable = 1'b1; bus_if.write_enable = 1'b0;
        cyc();
        d = bus_if.read_data;
        bus_if.read_enable = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        n_cmp  = 0;
        n_fail = 0;
        vtab[0]  = '{0, 1, 8'h10, 16'h0000, 16'h0000, 0};
        vtab[1]  = '{0, 1, 8'h11, 16'h0000, 16'hFFFF, 0};
        vtab[2]  = '{0, 1, 8'h12, 16'h0000, 16'h0000, 0};
        vtab[3]  = '{0, 1, 8'h13, 16'h0000, 16'h0000, 0};
        vtab[4]  = '{1, 0, 8'h14, 16'hFFFF, 16'h0000, 0};
        vtab[5]  = '{1, 0, 8'h0F, 16'hFFFF, 16'h0000, 0};
        vtab[6]  = '{1, 0, 8'h0D, 16'h1234, 16'h0000, 0};
        vtab[7]  = '{1, 0, 8'h0E, 16'h00FF, 16'h0000, 0};
        vtab[8]  = '{0, 1, 8'h14, 16'h0000, 16'h0000, 0};
        vtab[9]  = '{0, 1, 8'h0F, 16'h0000, 16'h0000, 0};
        vtab[10] = '{0, 1, 8'h10, 16'h0000, 16'h0000, 0};
        vtab[11] = '{0, 1, 8'h11, 16'h0000, 16'hFFFF, 0};
        vtab[12] = '{0, 1, 8'h12, 16'h0000, 16'h0000, 0};
        vtab[13] = '{0, 1, 8'h13, 16'h0000, 16'h0000, 0};

        idle();
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_rd", bus_if.read_data, 16'h0000);
        chk("reset_irq", 16'(bus_if.irq), 16'h0000);
        rst = 1'b0;

        // Reset values and out-of-window accesses.
        for (int i = 0; i < 14; i++) begin
            bus_if.write_enable = vtab[i].we;
            bus_if.read_enable  = vtab[i].re;
            bus_if.addr         = vtab[i].addr;
            bus_if.write_data   = vtab[i].wdata;
            cyc();
            chk($sformatf("vec%0d_rd", i), bus_if.read_data, vtab[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), 16'(bus_if.irq), 16'(vtab[i].exp_irq));
        end
        idle();

        // One-shot: match at the 6th tick edge, then enable drops and count holds.
        do_reset();
        wr(8'h11, 16'd5);
        wr(8'h10, 16'h0005);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("oneshot_irq_low", 16'(bus_if.irq), 16'h0000);
        end
        cyc();
        chk("oneshot_irq_high", 16'(bus_if.irq), 16'h0001);
        rd(8'h12, d); chk("oneshot_count", d, 16'd5);
        rd(8'h10, d); chk("oneshot_ctrl", d, 16'h0004);
        rd(8'h13, d); chk("oneshot_status", d, 16'h0001);

        // Auto-reload with prescale 2: count 0,1,2,3,0 and a match every 12 cycles.
        do_reset();
        wr(8'h11, 16'd3);
        wr(8'h10, 16'h0207);
        bus_if.addr = 8'h12; bus_if.read_enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            chk($sformatf("reload_count_k%0d", k), bus_if.read_data, 16'(((k - 1) / 3) % 4));
            chk($sformatf("reload_irq_k%0d", k), 16'(bus_if.irq), 16'(k >= 12));
        end
        bus_if.read_enable = 1'b0;
        wr(8'h13, 16'h0001);
        chk("w1c_clears_irq", 16'(bus_if.irq), 16'h0000);
        for (int k = 26; k <= 35; k++) cyc();
        wr(8'h13, 16'h0001);
        chk("w1c_vs_match_irq", 16'(bus_if.irq), 16'h0001);
        rd(8'h13, d); chk("w1c_vs_match_status", d, 16'h0003);

        // Wrap FFFF -> 0000 without a flag, then match at compare 0.
        do_reset();
        wr(8'h11, 16'h0000);
        wr(8'h12, 16'hFFFE);
        wr(8'h10, 16'h0005);
        bus_if.addr = 8'h12; bus_if.read_enable = 1'b1;
        cyc(); chk("wrap_rd1", bus_if.read_data, 16'hFFFE); chk("wrap_irq1", 16'(bus_if.irq), 16'h0000);
        cyc(); chk("wrap_rd2", bus_if.read_data, 16'hFFFF); chk("wrap_irq2", 16'(bus_if.irq), 16'h0000);
        cyc(); chk("wrap_rd3", bus_if.read_data, 16'h0000); chk("wrap_irq3", 16'(bus_if.irq), 16'h0001);
        cyc(); chk("wrap_rd4", bus_if.read_data, 16'h0000);
        bus_if.read_enable = 1'b0;

        // COUNT write landing on a tick edge wins over the increment.
        do_reset();
        wr(8'h10, 16'h0201);
        cyc();
        cyc();
        wr(8'h12, 16'h1234);
        rd(8'h12, d); chk("cntwr_tick_rd1", d, 16'h1234);
        rd(8'h12, d); chk("cntwr_tick_rd2", d, 16'h1234);
        rd(8'h12, d); chk("cntwr_tick_rd3", d, 16'h1234);
        rd(8'h12, d); chk("cntwr_tick_rd4", d, 16'h1235);

        // Read issued on the reset edge returns zero; state back to reset values.
        bus_if.addr = 8'h12; bus_if.read_enable = 1'b1;
        rst = 1'b1;
        cyc();
        chk("read_on_reset", bus_if.read_data, 16'h0000);
        rst = 1'b0;
        bus_if.read_enable = 1'b0;
        rd(8'h12, d); chk("post_reset_count", d, 16'h0000);
        rd(8'h11, d); chk("post_reset_compare", d, 16'hFFFF);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [15:0] w;
            r = int'($urandom_range(0, 99));
            if (r < 85)      bus_if.addr = BASE + 8'($urandom_range(0, 3));
            else if (r < 90) bus_if.addr = BASE - 8'd1;
            else if (r < 95) bus_if.addr = BASE + 8'd4;
            else             bus_if.addr = 8'($urandom);
            w = 16'($urandom);
            case (bus_if.addr[1:0])
                2'd0: w[15:8] = 8'($urandom_range(0, 3));
                2'd1: w = 16'($urandom_range(0, 12));
                2'd2: w = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom_range(0, 12));
                default: ;
            endcase
            bus_if.write_data   = w;
            bus_if.write_enable = ($urandom_range(0, 3) == 0);
            bus_if.read_enable  = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 249) == 0);
            cyc();
            chk("rand_rd", bus_if.read_data, m_rd);
            chk("rand_irq", 16'(bus_if.irq), 16'(m_match && m_ie));
        end
        rst = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
